snes_frame_arbiter: RTL
=======================

// Module: snes_frame_arbiter
// PURPOSE
//  Shares the single SNES console serial link between NUM_SRC button sources (physical pad, remote, macro).
//  Synchronises console SNES_latch/SNES_clk into the system clock domain and tracks each 16-bit frame.
//  Picks one owning source per frame and drives a word held stable for the whole frame.
//  frame_data feeds the serial shift-out translator's data input.
// PARAMETERS
//  NUM_SRC      2        number of requesting sources (>=1)
//  SYNC_STAGES  2        flip-flop stages on snes_latch / snes_clk (>=2)
//  HOLD_FRAMES  4        frames ownership persists after owner drops src_req (0..15)
//  TIMEOUT_CYC  1024     max clk cycles between console events inside a frame
//  IDLE_WORD    16'hFFFF word driven when no source owns the link (active-low buttons, none pressed)
// PORTS
//  clk          in   1            system clock, all logic on rising edge
//  reset        in   1            reset, asynchronous, active-high
//  snes_latch   in   1            console latch, asynchronous to clk
//  snes_clk     in   1            console data clock, asynchronous to clk
//  src_req      in   NUM_SRC      per-source request (source has buttons to send)
//  src_data     in   16*NUM_SRC   source i word at [16*i+15:16*i]
//  frame_data   out  16           word for the current frame
//  grant        out  NUM_SRC      one-hot owner, all-zero = no owner
//  frame_active out  1            high from latch rise until frame ends
//  bit_index    out  4            index of bit the console is currently reading (15 down to 0)
//  frame_done   out  1            1-cycle pulse, 16th snes_clk fall seen
//  overrun      out  1            1-cycle pulse, latch rise inside an unfinished frame
//  timeout      out  1            1-cycle pulse, frame abandoned for inactivity
// BEHAVIOUR
//  Reset: frame_data=IDLE_WORD, grant=0, bit_index=15, all 1-bit outputs 0, FSM=IDLE,
//   round-robin pointer=0, hold counter=0; effective immediately, including mid-frame.
//  Sync: SYNC_STAGES-deep chain per input, plus one edge-detect register; edge events are
//   1-cycle strobes, visible SYNC_STAGES+1 cycles after the pin edge.
//  FSM IDLE -> LATCH on latch rise; LATCH -> SHIFT on latch fall; SHIFT counts snes_clk falls;
//   16th fall -> DONE (frame_done=1 for 1 cycle) -> IDLE. frame_active=1 in LATCH/SHIFT.
//  bit_index: 15 on latch rise, decrements on each snes_clk fall in SHIFT, 0 at 16th fall,
//   returns to 15 in DONE. snes_clk edges in IDLE/LATCH ignored.
//  Arbitration only in the latch-rise cycle:
//   - owner kept if its src_req=1 (hold reloads to HOLD_FRAMES) or hold>0 (hold decrements);
//   - else round-robin search from pointer, first src_req=1 wins, pointer = winner+1 mod NUM_SRC,
//     hold=HOLD_FRAMES; none requesting -> grant=0.
//  frame_data registered in the latch-rise cycle: owner's src_data, or IDLE_WORD if grant=0;
//   held constant until next latch rise, even if src_data/src_req change.
//  Overrun: latch rise in LATCH/SHIFT -> overrun pulse, frame restarts (re-arbitrate, new snapshot,
//   bit_index=15, stay LATCH); no frame_done for the aborted frame.
//  Simultaneous latch rise and snes_clk fall in one cycle: latch wins, clk fall discarded.
//  Timeout: cycle counter cleared on every sync'd event; reaches TIMEOUT_CYC in LATCH/SHIFT ->
//   timeout pulse, FSM=IDLE, bit_index=15; frame_data and grant retained.
//  Ownership released (grant=0) only at a latch rise; never mid-frame.
// TESTING
//  1 src0 req, data 16'hFF7E; latch pulse + 16 clk falls -> grant=01, frame_data=FF7E, bit_index 15..0, one frame_done.
//  2 src0,src1 both req from reset; 3 frames -> grants 01,10,01 (pointer starts 0, owner drops req each frame).
//  3 src0 owns, drops req, src1 req; HOLD_FRAMES=4 -> src0 kept 4 more frames, src1 granted on frame 6.
//  4 src_data changes mid-SHIFT -> frame_data unchanged until next latch rise.
//  5 latch rise after 7 clk falls -> overrun pulse, bit_index=15, no frame_done; next 16 falls -> frame_done.
//  6 latch then no clk for TIMEOUT_CYC cycles -> timeout pulse, IDLE; reset asserted mid-SHIFT -> all reset values at once.

Source files
------------

// File: rtl/snes_frame_arbiter_if.sv
// snes_frame_arbiter_if
//   Bundles the source-side bus of the SNES frame arbiter.
//   master : the button sources and their consumer (drive requests and words,
//            observe ownership and frame status)
//   slave  : the arbiter itself
// Signals
//   src_req      NUM_SRC     per-source request
//   src_data     16*NUM_SRC  source i word at [16*i+15:16*i]
//   frame_data   16          word held for the current frame
//   grant        NUM_SRC     one-hot owner, zero = no owner
//   frame_active 1           frame in progress (latch or shift phase)
//   bit_index    4           bit the console is currently reading
//   frame_done   1           pulse, frame completed
//   overrun      1           pulse, frame restarted by an early latch
//   timeout      1           pulse, frame abandoned for inactivity
interface snes_frame_arbiter_if #(
  parameter int NUM_SRC = 2
);
  logic [NUM_SRC-1:0]    src_req;
  logic [16*NUM_SRC-1:0] src_data;
  logic [15:0]           frame_data;
  logic [NUM_SRC-1:0]    grant;
  logic                  frame_active;
  logic [3:0]            bit_index;
  logic                  frame_done;
  logic                  overrun;
  logic                  timeout;

  modport master (
    output src_req, src_data,
    input  frame_data, grant, frame_active, bit_index, frame_done, overrun, timeout
  );

  modport slave (
    input  src_req, src_data,
    output frame_data, grant, frame_active, bit_index, frame_done, overrun, timeout
  );
endinterface

// File: rtl/snes_frame_arbiter.sv
// snes_frame_arbiter
//   Shares one SNES console serial link between NUM_SRC button sources.
//   The console latch/clock pins are synchronised into the clk domain, each
//   16-bit frame is tracked, and one owning source is chosen per frame. The
//   owner's word is snapshotted at the latch rise and held for the whole frame.
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   snes_latch console latch pin (asynchronous to clk)
//   snes_clk   console data clock pin (asynchronous to clk)
//   bus        slave side of snes_frame_arbiter_if (requests, data, status)
module snes_frame_arbiter #(
  parameter int          NUM_SRC     = 2,
  parameter int          SYNC_STAGES = 2,
  parameter int          HOLD_FRAMES = 4,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [15:0] IDLE_WORD   = 16'hFFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               snes_latch,
  input  logic               snes_clk,
  snes_frame_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LATCH, ST_SHIFT, ST_DONE} state_t;

  state_t               state;
  logic [SYNC_STAGES-1:0] latch_sync, clk_sync;
  logic                 latch_prev, clk_prev;
  logic [CNT_W-1:0]     cyc_cnt;
  logic [IDX_W-1:0]     rr_ptr;
  logic [3:0]           hold_q;
  logic [15:0]          frame_data_q;
  logic [NUM_SRC-1:0]   grant_q;
  logic                 frame_active_q;
  logic [3:0]           bit_index_q;
  logic                 frame_done_q, overrun_q, timeout_q;

  logic                 latch_s, clk_s;
  logic                 latch_rise, latch_fall, clk_fall, any_event, timed_out;
  logic                 in_frame;
  logic [NUM_SRC-1:0]   arb_grant;
  logic [3:0]           arb_hold;
  logic [IDX_W-1:0]     arb_ptr;
  logic                 arb_found;
  logic [15:0]          arb_data;

  // Synchroniser chains plus one register each for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_sync <= '0;
      clk_sync   <= '0;
      latch_prev <= 1'b0;
      clk_prev   <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], snes_latch};
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], snes_clk};
      latch_prev <= latch_sync[SYNC_STAGES-1];
      clk_prev   <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign clk_s      = clk_sync[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_prev;
  assign latch_fall = ~latch_s & latch_prev;
  assign clk_fall   = ~clk_s & clk_prev;
  assign any_event  = (latch_s ^ latch_prev) | (clk_s ^ clk_prev);
  assign in_frame   = (state == ST_LATCH) || (state == ST_SHIFT);
  // The counter holds the cycles already elapsed, so this cycle is the one
  // in which the inactivity count reaches TIMEOUT_CYC.
  assign timed_out  = in_frame && !any_event && (cyc_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Next owner, evaluated every cycle but only committed on a latch rise.
  // An owner that still requests, or still has hold credit, keeps the link;
  // otherwise the round-robin search starts at the pointer.
  always_comb begin
    arb_grant = '0;
    arb_hold  = 4'd0;
    arb_ptr   = rr_ptr;
    arb_found = 1'b0;
    if ((|grant_q) && ((|(grant_q & bus.src_req)) || (hold_q != 4'd0))) begin
      arb_grant = grant_q;
      arb_hold  = (|(grant_q & bus.src_req)) ? 4'(HOLD_FRAMES) : hold_q - 4'd1;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (!arb_found && bus.src_req[(int'(rr_ptr) + k) % NUM_SRC]) begin
          arb_found = 1'b1;
          arb_grant[(int'(rr_ptr) + k) % NUM_SRC] = 1'b1;
          arb_ptr   = IDX_W'((int'(rr_ptr) + k + 1) % NUM_SRC);
          arb_hold  = 4'(HOLD_FRAMES);
        end
      end
    end
  end

  // Word the new owner would present; IDLE_WORD when nobody owns the link.
  always_comb begin
    arb_data = IDLE_WORD;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (arb_grant[i]) arb_data = bus.src_data[16*i +: 16];
    end
  end

  // Frame FSM with registered outputs. A latch rise always wins over any
  // other event in the same cycle and restarts the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      cyc_cnt        <= '0;
      rr_ptr         <= '0;
      hold_q         <= 4'd0;
      frame_data_q   <= IDLE_WORD;
      grant_q        <= '0;
      frame_active_q <= 1'b0;
      bit_index_q    <= 4'd15;
      frame_done_q   <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;

      if (any_event || !in_frame) cyc_cnt <= '0;
      else                        cyc_cnt <= cyc_cnt + 1'b1;

      if (latch_rise) begin
        overrun_q      <= in_frame;
        grant_q        <= arb_grant;
        hold_q         <= arb_hold;
        rr_ptr         <= arb_ptr;
        frame_data_q   <= arb_data;
        bit_index_q    <= 4'd15;
        frame_active_q <= 1'b1;
        state          <= ST_LATCH;
      end else begin
        case (state)
          ST_LATCH: begin
            if (latch_fall) begin
              state <= ST_SHIFT;
            end else if (timed_out) begin
              timeout_q      <= 1'b1;
              frame_active_q <= 1'b0;
              bit_index_q    <= 4'd15;
              state          <= ST_IDLE;
            end
          end
          ST_SHIFT: begin
            // bit_index already at 0 means this fall is the 16th one.
            if (clk_fall) begin
              if (bit_index_q == 4'd0) begin
                frame_done_q   <= 1'b1;
                frame_active_q <= 1'b0;
                state          <= ST_DONE;
              end else begin
                bit_index_q <= bit_index_q - 4'd1;
              end
            end else if (timed_out) begin
              timeout_q      <= 1'b1;
              frame_active_q <= 1'b0;
              bit_index_q    <= 4'd15;
              state          <= ST_IDLE;
            end
          end
          ST_DONE: begin
            bit_index_q <= 4'd15;
            state       <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.frame_data   = frame_data_q;
  assign bus.grant        = grant_q;
  assign bus.frame_active = frame_active_q;
  assign bus.bit_index    = bit_index_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.overrun      = overrun_q;
  assign bus.timeout      = timeout_q;

endmodule
